// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, FSM states and feed/output row mapping for the Sobel row sequencer
// Optional edge replication: SOBEL_SEQ_EDGE_REPLICATE_EN
package sobel_pkg;

  localparam int SOBEL_ROW   = 256;
  localparam int SOBEL_WIDTH = 8;
  localparam int PIX_W       = 3 * SOBEL_WIDTH;
  localparam int ROW_W       = SOBEL_ROW * PIX_W;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_FEED,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

`ifdef SOBEL_SEQ_EDGE_REPLICATE_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  function automatic int num_strobes(input int rows);
    return rows + 2 * PAD;
  endfunction

  // With padding the first and last image rows are fed twice.
  function automatic int feed_addr(input int f, input int rows);
    int a;
    a = f - PAD;
    if (a < 0) a = 0;
    if (a > rows - 1) a = rows - 1;
    return a;
  endfunction

  // f_next is the feed counter after the strobe that produced the result.
  function automatic int out_index(input int f_next);
    return f_next - 2 - PAD;
  endfunction

endpackage

// File: rtl/row_hold_reg.sv
// rtl/row_hold_reg.sv - single-entry valid/ready output register; load and accept may share an edge
module row_hold_reg #(
  parameter int DW = 8,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [IW-1:0] idx_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      idx_d   = idx_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/sobel_row_sequencer.sv
// rtl/sobel_row_sequencer.sv - frame controller feeding rows to the Sobel engine and holding results
// Optional edge replication: SOBEL_SEQ_EDGE_REPLICATE_EN
module sobel_row_sequencer
  import sobel_pkg::*;
#(
  parameter int ROW   = SOBEL_ROW,
  parameter int WIDTH = SOBEL_WIDTH,
  parameter int AW    = $clog2(ROW)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd,
  output logic [AW-1:0]          mem_addr,
  input  logic [ROW*WIDTH*3-1:0] mem_rdata,
  output logic [ROW*WIDTH*3-1:0] sobel_row,
  output logic                   sobel_stb,
  output logic                   sobel_set,
  output logic                   sobel_rst,
  input  logic [ROW*WIDTH*3-1:0] sobel_out,
  output logic [ROW*WIDTH*3-1:0] out_row,
  output logic [AW-1:0]          out_idx,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int RW = ROW * WIDTH * 3;
  localparam int FW = AW + 2;
  localparam logic [FW-1:0] F_LAST  = FW'(num_strobes(ROW));
  localparam logic [FW-1:0] F_PRIME = FW'(2);

  state_t        state_q, state_d;
  logic [FW-1:0] f_q, f_d;
  logic [RW-1:0] row_q, row_d;
  logic          stall;
  logic          cap_load;
  logic [AW-1:0] cap_idx;

  // An unconsumed result blocks the next read so the engine window never advances past it.
  assign stall = out_valid && !out_ready;

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    row_d     = row_q;
    mem_rd    = 1'b0;
    sobel_stb = 1'b0;
    sobel_set = 1'b0;
    sobel_rst = 1'b1;
    cap_load  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sobel_rst = 1'b0;
          f_d       = '0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!stall) begin
          mem_rd  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        row_d   = mem_rdata;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        sobel_stb = 1'b1;
        sobel_set = (f_q != '0);
        f_d       = f_q + 1'b1;
        state_d   = (f_q < F_PRIME) ? ST_FETCH : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cap_load = 1'b1;
        state_d  = (f_q == F_LAST) ? ST_DRAIN : ST_FETCH;
      end
      ST_DRAIN: begin
        if (out_valid && out_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      row_q   <= row_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign sobel_row = row_q;
  assign mem_addr  = AW'(feed_addr(int'(f_q), ROW));
  assign cap_idx   = AW'(out_index(int'(f_q)));

  row_hold_reg #(
    .DW (RW),
    .IW (AW)
  ) u_hold (
    .clk     (CLK),
    .rst_n   (RST),
    .load_i  (cap_load),
    .data_i  (sobel_out),
    .idx_i   (cap_idx),
    .ready_i (out_ready),
    .data_o  (out_row),
    .idx_o   (out_idx),
    .valid_o (out_valid)
  );

endmodule

// File: tb/tb_sobel_row_sequencer.sv
// tb/tb_sobel_row_sequencer.sv - directed bench for sobel_row_sequencer with RAM and engine models
module tb_sobel_row_sequencer;

  localparam int ROW   = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int RW    = ROW * WIDTH * 3;
`ifdef SOBEL_SEQ_EDGE_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam int NS    = REP ? ROW + 2 : ROW;
  localparam int NOUT  = REP ? ROW : ROW - 2;
  localparam int FIRST = REP ? 0 : 1;
  localparam int LAT   = 2 * 3 + NOUT * 4 + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, mem_rd, sobel_stb, sobel_set, sobel_rst, out_valid;
  logic          out_ready;
  logic [AW-1:0] mem_addr, out_idx;
  logic [RW-1:0] mem_rdata, sobel_row, sobel_out, out_row;

  int total = 0;
  int bad   = 0;
  int img_mode = 0;

  sobel_row_sequencer #(.ROW(ROW), .WIDTH(WIDTH), .AW(AW)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .sobel_row (sobel_row),
    .sobel_stb (sobel_stb),
    .sobel_set (sobel_set),
    .sobel_rst (sobel_rst),
    .sobel_out (sobel_out),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int r);
    return (r < 0) ? 0 : (r > ROW - 1) ? ROW - 1 : r;
  endfunction

  function automatic logic [7:0] pix_val(input int r);
    case (img_mode)
      0:       return 8'(r);
      1:       return 8'(3 * r + 5);
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [RW-1:0] img_row(input int r);
    logic [7:0] v;
    v = pix_val(r);
    return {(ROW * 3){v}};
  endfunction

  // Toy engine: R = middle row, G = bottom - top (vertical gradient), B = top row.
  function automatic logic [RW-1:0] engine(input logic [RW-1:0] top, input logic [RW-1:0] mid,
                                           input logic [RW-1:0] bot);
    logic [RW-1:0] o;
    o = '0;
    for (int p = 0; p < ROW; p++) begin
      o[24*p+16 +: 8] = mid[24*p+16 +: 8];
      o[24*p+8  +: 8] = bot[24*p+8 +: 8] - top[24*p+8 +: 8];
      o[24*p    +: 8] = top[24*p +: 8];
    end
    return o;
  endfunction

  function automatic logic [RW-1:0] exp_row(input int i);
    logic [7:0]  t, m, b;
    logic [23:0] px;
    t  = pix_val(clamp(i - 1));
    m  = pix_val(i);
    b  = pix_val(clamp(i + 1));
    px = {m, 8'(b - t), t};
    return {ROW{px}};
  endfunction

  function automatic int exp_addr(input int k);
    return REP ? clamp(k - 1) : k;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_rd ? img_row(int'(mem_addr)) : '1;
  end

  logic [RW-1:0] w_mid, w_bot;
  always @(posedge clk) begin
    if (!rst_n || !sobel_rst) begin
      w_mid     <= '0;
      w_bot     <= '0;
      sobel_out <= '1;
    end else if (sobel_stb) begin
      if (sobel_set) begin
        sobel_out <= engine(w_mid, w_bot, sobel_row);
        w_mid     <= w_bot;
      end else begin
        sobel_out <= engine('0, '0, sobel_row);
        w_mid     <= '0;
      end
      w_bot <= sobel_row;
    end else begin
      sobel_out <= '1;
    end
  end

  int            ncnt = 0, t0 = 0, done_cnt = 0, done_rel = -1, rst_lo_cnt = 0;
  logic [AW-1:0] rd_q[$];
  bit            set_q[$];
  logic [7:0]    stbv_q[$];
  logic [AW-1:0] idx_q[$];
  logic [RW-1:0] row_q[$];

  // Sampled one unit before each rising edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    #4;
    if (mem_rd) rd_q.push_back(mem_addr);
    if (sobel_stb) begin
      set_q.push_back(sobel_set);
      stbv_q.push_back(sobel_row[7:0]);
    end
    if (out_valid && out_ready) begin
      idx_q.push_back(out_idx);
      row_q.push_back(out_row);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_rel = ncnt - t0;
    end
    if (!sobel_rst) rst_lo_cnt = rst_lo_cnt + 1;
    ncnt = ncnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_sobel_row"}, sobel_row, 0);
    check({tag, "_sobel_stb"}, sobel_stb, 0);
    check({tag, "_sobel_set"}, sobel_set, 0);
    check({tag, "_sobel_rst"}, sobel_rst, 1);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_valid"}, out_valid, 0);
  endtask

  task automatic start_frame(input int mode);
    tick();
    img_mode = mode;
    rd_q.delete();
    set_q.delete();
    stbv_q.delete();
    idx_q.delete();
    row_q.delete();
    done_cnt   = 0;
    done_rel   = -1;
    rst_lo_cnt = 0;
    t0         = ncnt;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt != 0, 1);
    tick();
    tick();
    check("done_single_pulse", done_cnt, 1);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_frame(input bit timed);
    if (timed) check("latency", done_rel, LAT);
    check("n_reads", rd_q.size(), NS);
    check("n_strobes", set_q.size(), NS);
    for (int k = 0; k < rd_q.size() && k < NS; k++)
      check($sformatf("addr%0d", k), rd_q[k], exp_addr(k));
    for (int k = 0; k < set_q.size() && k < NS; k++) begin
      check($sformatf("set%0d", k), set_q[k], k != 0);
      check($sformatf("stbrow%0d", k), stbv_q[k], pix_val(exp_addr(k)));
    end
    check("n_out", idx_q.size(), NOUT);
    for (int j = 0; j < idx_q.size() && j < NOUT; j++) begin
      check($sformatf("idx%0d", j), idx_q[j], FIRST + j);
      check($sformatf("row%0d", j), row_q[j], exp_row(FIRST + j));
    end
    check("sobel_rst_pulses", rst_lo_cnt, 1);
  endtask

  logic [RW-1:0] hold_row;
  logic [AW-1:0] hold_idx;
  int            n, bad_stb, bad_rd, moved;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // ramp image, no backpressure
    start_frame(0);
    wait_done(400);
    check_frame(1'b1);

    // backpressure from the first output, with a stray start during the stall
    out_ready = 1'b0;
    start_frame(1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("first_valid", out_valid, 1);
    check("first_idx", out_idx, FIRST);
    hold_row = out_row;
    hold_idx = out_idx;
    bad_stb  = 0;
    bad_rd   = 0;
    moved    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      if (sobel_stb) bad_stb++;
      if (mem_rd) bad_rd++;
      if (out_row !== hold_row || out_idx !== hold_idx || out_valid !== 1'b1) moved++;
    end
    check("stall_no_stb", bad_stb, 0);
    check("stall_no_rd", bad_rd, 0);
    check("stall_hold_stable", moved, 0);
    check("stall_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(600);
    check_frame(1'b0);

    // reset in the middle of the frame, then a full clean frame
    start_frame(0);
    n = 0;
    while (rd_q.size() < (REP ? 6 : 5) && n < 100) begin
      tick();
      n++;
    end
    check("reached_row4", busy, 1);
    rst_n = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    tick();
    start_frame(0);
    wait_done(400);
    check_frame(1'b1);

    // uniform 0x80 image: zero vertical gradient everywhere
    start_frame(2);
    wait_done(400);
    check_frame(1'b1);
    for (int j = 0; j < row_q.size(); j++)
      check($sformatf("uniform_row%0d", j), row_q[j], {(ROW){8'h80, 8'h00, 8'h80}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
